// File: rtl/rvr32_pkg.sv
// ============================================================================
// Module   : rvr32_pkg
// Purpose  : Shared types and constants for the RVR32 PC sequencing logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvr32_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_TRAP = 2'd1,
    RD_JMP  = 2'd2,
    RD_BR   = 2'd3
  } redir_e;

  localparam logic [31:0] RVR32_PC_STEP  = 32'd4;
  localparam logic [31:0] RVR32_TRAP_VEC = 32'h0000_0100;

endpackage

`default_nettype wire

// File: rtl/rvr32_pc_redirect_sel.sv
// ============================================================================
// Module   : rvr32_pc_redirect_sel
// Purpose  : Priority encoder (trap > jump > taken branch) for PC redirects.
//            Optional macro: RVR32_PC_MISALIGN_EN (misaligned target -> trap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvr32_pc_redirect_sel
  import rvr32_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = RVR32_TRAP_VEC
) (
  input  logic        trap_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_tgt_i,
  input  logic        br_i,
  input  logic [31:0] br_off_i,
  output redir_e      winner_o,
  output logic        pc_jmp_o,
  output logic [31:0] pc_jdata_o,
  output logic        pc_brj_o,
  output logic [31:0] pc_bjimm_o,
  output logic        misalign_o
);

`ifdef RVR32_PC_MISALIGN_EN
  localparam logic        MIS_EN    = 1'b1;
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF;
`else
  localparam logic        MIS_EN    = 1'b0;
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFC;
`endif

  always_comb begin
    winner_o   = RD_NONE;
    pc_jmp_o   = 1'b0;
    pc_jdata_o = 32'h0;
    pc_brj_o   = 1'b0;
    pc_bjimm_o = 32'h0;
    misalign_o = 1'b0;
    if (trap_i) begin
      winner_o   = RD_TRAP;
      pc_jmp_o   = 1'b1;
      pc_jdata_o = TRAP_VEC;
    end else if (jmp_i) begin
      // A misaligned target is turned into a trap entry instead of a jump.
      if (MIS_EN && (jmp_tgt_i[1:0] != 2'b00)) begin
        winner_o   = RD_TRAP;
        pc_jmp_o   = 1'b1;
        pc_jdata_o = TRAP_VEC;
        misalign_o = 1'b1;
      end else begin
        winner_o   = RD_JMP;
        pc_jmp_o   = 1'b1;
        pc_jdata_o = jmp_tgt_i & DATA_MASK;
      end
    end else if (br_i) begin
      if (MIS_EN && (br_off_i[1:0] != 2'b00)) begin
        winner_o   = RD_TRAP;
        pc_jmp_o   = 1'b1;
        pc_jdata_o = TRAP_VEC;
        misalign_o = 1'b1;
      end else begin
        winner_o   = RD_BR;
        pc_brj_o   = 1'b1;
        pc_bjimm_o = br_off_i & DATA_MASK;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvr32_pc_ctrl.sv
// ============================================================================
// Module   : rvr32_pc_ctrl
// Purpose  : PC sequencing FSM (BOOT/RUN/FLUSH/HALT) driving the PC register.
//            Optional macro: RVR32_PC_MISALIGN_EN (see rvr32_pc_redirect_sel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvr32_pc_ctrl
  import rvr32_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_VEC     = RVR32_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_off,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_tgt,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_we,
  output logic        pc_jmp,
  output logic [31:0] pc_jdata,
  output logic        pc_brj,
  output logic [31:0] pc_bjimm,
  output logic        flush,
  output logic        halted,
  output logic        misalign
);

  localparam int             CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

  pc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic   sel_trap, sel_jmp, sel_br, redirect;
  redir_e winner;

  // Jump/branch only compete in RUN; in FLUSH their producers are being killed.
  assign sel_trap = ((state_q == ST_RUN) && (trap_req || pend_q)) ||
                    ((state_q == ST_FLUSH) && trap_req);
  assign sel_jmp  = (state_q == ST_RUN) && jmp_valid;
  assign sel_br   = (state_q == ST_RUN) && br_valid && br_taken;
  assign redirect = (winner != RD_NONE);

  rvr32_pc_redirect_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_sel (
    .trap_i     (sel_trap),
    .jmp_i      (sel_jmp),
    .jmp_tgt_i  (jmp_tgt),
    .br_i       (sel_br),
    .br_off_i   (br_off),
    .winner_o   (winner),
    .pc_jmp_o   (pc_jmp),
    .pc_jdata_o (pc_jdata),
    .pc_brj_o   (pc_brj),
    .pc_bjimm_o (pc_bjimm),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pc_we   = 1'b0;
    flush   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (trap_req) pend_d = 1'b1;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_we  = 1'b1;
          flush  = 1'b1;
          pend_d = 1'b0;
          cnt_d  = CNT_LOAD;
          if (FLUSH_CYCLES > 0) state_d = ST_FLUSH;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else begin
          pc_we = fetch_ready && !stall;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          pc_we = 1'b1;
          flush = 1'b1;
          cnt_d = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (trap_req) pend_d = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/rvr32_pc_ctrl.md
Name: rvr32_pc_ctrl

Overview:
Sequencing controller for the shared PC register.
- Arbitrates redirect sources (trap, jump, taken branch) against sequential fetch advance.
- Drives the PC register's write-enable, jump, branch and data controls.
- Enforces a post-redirect flush window and a debug halt/resume with one buffered pending trap.
- Sits between fetch, branch/jump units, trap logic and the PC register.

Parameters:
FLUSH_CYCLES, 2, cycles PC is frozen after any redirect (0 = none).
TRAP_VEC, 32'h0000_0100, absolute trap entry address.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_ready  in  1  fetch consumed current PC; sequential advance allowed
stall  in  1  backend hazard; blocks sequential advance only
br_valid  in  1  branch resolved this cycle
br_taken  in  1  branch outcome; qualified by br_valid
br_off  in  32  branch offset, relative to current PC value
jmp_valid  in  1  absolute jump request
jmp_tgt  in  32  jump target
trap_req  in  1  trap entry request
halt_req  in  1  debug halt request
resume  in  1  debug resume
pc_we  out  1  PC register write enable
pc_jmp  out  1  select absolute data
pc_jdata  out  32  absolute target
pc_brj  out  1  select PC+offset instead of PC+4
pc_bjimm  out  32  relative offset
flush  out  1  one-cycle pipeline kill pulse
halted  out  1  controller in HALT
misalign  out  1  misaligned target detected (optional feature only)

Behaviour:
- States: BOOT, RUN, FLUSH, HALT; 2-bit state; FLUSH_CYCLES-wide down-counter; 1-bit pending_trap.
- Command outputs are combinational from state plus inputs; state, counter and pending_trap are registered.
- Reset: state=BOOT, counter=0, pending_trap=0. All outputs 0 while rst_n=0 and during BOOT.
- BOOT lasts exactly one cycle, then RUN. A request present in BOOT is ignored, except trap_req, which sets pending_trap.

RUN priority: trap > jump > taken branch > halt > sequential.
- trap_req or pending_trap: pc_we=1, pc_jmp=1, pc_jdata=TRAP_VEC. Clears pending_trap.
- jmp_valid: pc_we=1, pc_jmp=1, pc_jdata=jmp_tgt.
- br_valid && br_taken: pc_we=1, pc_brj=1, pc_bjimm=br_off.
- Any redirect: flush=1 the same cycle, load counter=FLUSH_CYCLES, and go to FLUSH. If FLUSH_CYCLES=0, stay in RUN.
- Redirects apply regardless of stall. Lower-priority simultaneous requests are dropped, not buffered.
- halt_req with no redirect: pc_we=0, go to HALT.
- Otherwise: pc_we = fetch_ready && !stall, with pc_jmp=pc_brj=0 (PC+4).
- Not-taken branch (br_valid && !br_taken): sequential rules apply.
- Data outputs: pc_jdata and pc_bjimm are 0 when their select is inactive.

FLUSH:
- pc_we=0. Counter decrements each cycle; on the cycle it reaches 1, next state is RUN.
- Jump and branch requests are ignored (their producers are being flushed).
- trap_req redirects immediately: flush pulse, counter reloaded.
- halt_req is remembered only if still asserted on return to RUN.

HALT:
- pc_we=0, halted=1.
- trap_req sets pending_trap; jump and branch are ignored.
- resume goes to RUN next cycle. If pending_trap is set, the first RUN cycle performs the trap redirect.
- resume and halt_req together: resume wins.

Other:
- Async reset mid-FLUSH or mid-HALT returns to BOOT and clears pending_trap.
- Address arithmetic is done by the PC register. This block never adds; wrap-around is the PC register's modulo-2^32 behaviour.

Optional Feature:
RVR32_PC_MISALIGN_EN
- Defined: a jump whose jmp_tgt[1:0]!=0, or a taken branch whose br_off[1:0]!=0, is replaced by a trap redirect to TRAP_VEC with misalign=1 for that cycle. Flush and FLUSH entry proceed as for a trap.
- Undefined: misalign tied 0; pc_jdata[1:0] and pc_bjimm[1:0] forced to 0; no extra trap.

Decomposition:
- Shared package rvr32_pkg holds:
  - state encoding constants (BOOT/RUN/FLUSH/HALT);
  - RVR32_PC_STEP=4;
  - default TRAP_VEC.
- One natural combinational sub-module, rvr32_pc_redirect_sel: the priority encoder producing winner, pc_jmp, pc_brj and the data selects. The FSM stays in the top.

Test Plan:
- Release reset, fetch_ready=1, stall=0 → pc_we=0 in BOOT cycle, then pc_we=1, pc_jmp=0, pc_brj=0 every cycle (PC 0,4,8,12).
- RUN: jmp_valid=1, jmp_tgt=0x200 together with br_valid=1, br_taken=1, br_off=0x40 → pc_jmp=1, pc_jdata=0x200, pc_brj=0, flush=1; next 2 cycles pc_we=0; then sequential resumes.
- stall=1 with taken branch br_off=0xFFFF_FFF8 → pc_we=1, pc_brj=1, pc_bjimm=0xFFFF_FFF8 despite stall; stall alone → pc_we=0.
- FLUSH cycle 1: trap_req=1 → pc_jdata=0x100, flush=1, counter reloaded to 2 (two more frozen cycles).
- halt_req → halted=1; trap_req during HALT; resume → first RUN cycle pc_jmp=1, pc_jdata=0x100, flush=1; pending_trap cleared.
- With RVR32_PC_MISALIGN_EN: jmp_tgt=0x202 → misalign=1, pc_jdata=0x100; without the macro → pc_jdata=0x200, misalign=0.
